alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 4..32).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum number of cycles spent waiting for a missing operand (legal 2..255).
REQ-003 SHALL have port CLK  input  1  sole clock; every register updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CE  input  1  clock enable; when low, all state and outputs hold.
REQ-006 SHALL have port MODE  input  1  operation class: 1 = arithmetic, 0 = logical.
REQ-007 SHALL have port CMD  input  4  operation code.
REQ-008 SHALL have port INP_VALID  input  2  operand valids: bit0 = OPA, bit1 = OPB.
REQ-009 SHALL have ports OPA and OPB  input  WIDTH  operands.
REQ-010 SHALL have port CIN  input  1  carry-in.
REQ-011 SHALL have port RES  output  2*WIDTH  result.
REQ-012 SHALL have port RES_VALID  output  1  one-cycle pulse marking a new RES and flags.
REQ-013 SHALL have ports COUT, OFLOW, ERR, G, L, E  output  1 each  carry, overflow, error, greater, less, equal.

Function
REQ-014 SHALL decode arithmetic commands (MODE=1):
- 0 ADD, 1 SUB, 2 ADD+CIN, 3 SUB-CIN
- 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B
- 8 CMP
- 9 MUL_INC = (A+1)*(B+1), 10 MUL_SHL = (A<<1)*B
REQ-015 SHALL decode logical commands (MODE=0):
- 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR
- 6 NOT_A, 7 NOT_B
- 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B
- 12 ROL_A_B, 13 ROR_A_B: rotate A by B[log2(WIDTH)-1:0]
REQ-016 SHALL treat any unlisted MODE/CMD pair as illegal: RES_VALID=1, ERR=1, RES=0, all other flags 0.
REQ-017 SHALL run a four-state FSM:
- IDLE -> EXEC when CE=1 and the required operands are valid.
- IDLE -> WAIT when a two-operand command arrives with only one operand valid.
- WAIT -> EXEC when the missing operand becomes valid.
- WAIT -> IDLE with ERR=1 after TIMEOUT cycles without it.
- EXEC -> MUL for multiply commands; all other completions return to IDLE.
REQ-018 SHALL latch CMD, MODE, CIN and each operand when its valid bit is seen; CMD/MODE changes during WAIT are ignored.
REQ-019 SHALL treat single-operand commands (INC/DEC, NOT, shifts) as needing only their own operand's valid bit.
REQ-020 SHALL deliver non-multiply results with RES_VALID exactly 1 cycle after the accepting edge.
REQ-021 SHALL deliver multiply results 2 cycles after the accepting edge.
REQ-022 SHALL zero-extend every RES; arithmetic results use RES[WIDTH:0] and logical results use RES[WIDTH-1:0].
REQ-023 SHALL set COUT on carry-out of ADD/ADD+CIN/INC, and OFLOW on borrow of SUB/SUB-CIN/DEC.
REQ-024 SHALL assert, for CMP, exactly one of G/L/E for unsigned A vs B, with RES=0.
REQ-025 SHALL set ERR for ROL/ROR when any bit of B above log2(WIDTH)-1 is set; RES is still computed.
REQ-026 SHALL hold RES and flags stable between RES_VALID pulses.
REQ-027 SHALL accept no new command while in WAIT, EXEC or MUL; inputs presented then are dropped.
REQ-028 SHALL freeze the FSM, the timeout counter and any in-flight multiply while CE=0, resuming without loss when CE returns to 1.

Reset
REQ-029 SHALL, with RST=1 at a rising edge, drive RES=0 and RES_VALID=COUT=OFLOW=ERR=G=L=E=0, set the FSM to IDLE, and clear the timeout counter and latched operands, regardless of CE.
REQ-030 SHALL abandon any in-flight multiply or WAIT when reset is asserted mid-operation, producing no RES_VALID for it.

Configuration
REQ-031 SHALL, with macro ALU_PIPE_MUL_EN defined, implement CMD 9/10 (MODE=1) as a 2-stage registered multiplier.
REQ-032 SHALL, without ALU_PIPE_MUL_EN, treat CMD 9/10 (MODE=1) as illegal per REQ-016 with 1-cycle latency and instantiate no multiplier.

Verification
REQ-033 SHALL cover, with WIDTH=8: ADD OPA=8'hFF, OPB=8'h01, INP_VALID=11 -> next cycle RES=16'h0100, COUT=1, RES_VALID=1.
REQ-034 SHALL cover: MUL_INC OPA=3, OPB=4 with ALU_PIPE_MUL_EN -> RES=20 two cycles later; without the macro -> ERR=1 one cycle later.
REQ-035 SHALL cover: SUB with INP_VALID=01 then 10 three cycles later -> RES valid one cycle after the second valid; a second run never supplying OPB -> ERR=1 after 16 cycles.
REQ-036 SHALL cover: CMP OPA=5, OPB=9 -> L=1, G=0, E=0; ROL OPA=8'h81, OPB=8'h09 -> ERR=1, RES=8'h03.
REQ-037 SHALL cover: RST=1 during WAIT and during MUL -> no RES_VALID, all outputs 0 on the next edge; CE=0 for 5 cycles mid-multiply -> result delayed exactly 5 cycles.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: operand-handshake ALU with one-cycle result latency and a missing-operand timeout.
// Macro ALU_PIPE_MUL_EN enables the 2-stage multiplier for arithmetic CMD 9/10.
module alu_pipe #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               MODE,
  input  logic [3:0]         CMD,
  input  logic [1:0]         INP_VALID,
  input  logic [WIDTH-1:0]   OPA,
  input  logic [WIDTH-1:0]   OPB,
  input  logic               CIN,
  output logic [2*WIDTH-1:0] RES,
  output logic               RES_VALID,
  output logic               COUT,
  output logic               OFLOW,
  output logic               ERR,
  output logic               G,
  output logic               L,
  output logic               E
);
  localparam int SH = $clog2(WIDTH);
  localparam int CW = $clog2(TIMEOUT);
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_MUL} state_t;
  state_t r_state, w_state_next;

  logic               r_mode, r_cin;
  logic [3:0]         r_cmd;
  logic [WIDTH-1:0]   r_opa, r_opb;
  logic [1:0]         r_have;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_res;
  logic               r_res_valid, r_cout, r_oflow, r_err, r_g, r_l, r_e;

  // Returns {legal, need[1:0]}; need bit0 = OPA, bit1 = OPB.
  function automatic logic [2:0] f_decode(input logic mode, input logic [3:0] cmd);
    logic [1:0] need;
    logic       legal;
    need  = 2'b11;
    legal = 1'b1;
    if (mode) begin
      case (cmd)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd8: need = 2'b11;
        4'd4, 4'd5:                   need = 2'b01;
        4'd6, 4'd7:                   need = 2'b10;
        4'd9, 4'd10:                  legal = MUL_EN;
        default:                      legal = 1'b0;
      endcase
    end else begin
      case (cmd)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13: need = 2'b11;
        4'd6, 4'd8, 4'd9:                                 need = 2'b01;
        4'd7, 4'd10, 4'd11:                               need = 2'b10;
        default:                                          legal = 1'b0;
      endcase
    end
    return {legal, need};
  endfunction

  function automatic logic f_is_mul(input logic mode, input logic [3:0] cmd);
    return MUL_EN && mode && (cmd == 4'd9 || cmd == 4'd10);
  endfunction

  logic [2:0] w_dec_in, w_dec_lat;
  logic [1:0] w_missing;
  logic       w_is_mul, w_accept, w_park, w_fill, w_timeout;

  assign w_dec_in  = f_decode(MODE, CMD);
  assign w_dec_lat = f_decode(r_mode, r_cmd);
  assign w_is_mul  = f_is_mul(r_mode, r_cmd);
  assign w_missing = w_dec_lat[1:0] & ~r_have;
  assign w_fill    = (r_state == S_WAIT) && ((INP_VALID & w_missing) == w_missing);
  assign w_timeout = (r_state == S_WAIT) && !w_fill && (r_cnt == CW'(TIMEOUT - 1));

  // Illegal commands are accepted on any valid bit so they report ERR promptly.
  always_comb begin
    w_accept = 1'b0;
    w_park   = 1'b0;
    if (r_state == S_IDLE) begin
      if (!w_dec_in[2])                                       w_accept = |INP_VALID;
      else if ((INP_VALID & w_dec_in[1:0]) == w_dec_in[1:0])  w_accept = 1'b1;
      else if (w_dec_in[1:0] == 2'b11 && |INP_VALID)          w_park   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)     r_state <= S_IDLE;
    else if (CE) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)    w_state_next = S_EXEC;
        else if (w_park) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_fill)         w_state_next = S_EXEC;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_EXEC:  w_state_next = w_is_mul ? S_MUL : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mode <= 1'b0;
      r_cmd  <= '0;
      r_cin  <= 1'b0;
      r_opa  <= '0;
      r_opb  <= '0;
      r_have <= '0;
      r_cnt  <= '0;
    end else if (CE) begin
      if (w_accept || w_park) begin
        r_mode <= MODE;
        r_cmd  <= CMD;
        r_cin  <= CIN;
        r_have <= INP_VALID;
        r_cnt  <= '0;
        if (INP_VALID[0]) r_opa <= OPA;
        if (INP_VALID[1]) r_opb <= OPB;
      end else if (r_state == S_WAIT) begin
        if (w_fill) begin
          if (w_missing[0]) r_opa <= OPA;
          if (w_missing[1]) r_opb <= OPB;
          r_have <= 2'b11;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  logic [WIDTH:0]     w_ea, w_eb, w_cin_x, w_sum;
  logic [WIDTH-1:0]   w_log, w_rol, w_ror;
  logic [SH-1:0]      w_amt;
  logic [2*WIDTH-1:0] w_res;
  logic               w_cout, w_oflow, w_err, w_g, w_l, w_e;

  assign w_ea    = {1'b0, r_opa};
  assign w_eb    = {1'b0, r_opb};
  assign w_cin_x = {{WIDTH{1'b0}}, r_cin};
  assign w_amt   = SH'(r_opb[SH-1:0] % WIDTH);
  assign w_rol   = (r_opa << w_amt) | (r_opa >> (WIDTH - int'(w_amt)));
  assign w_ror   = (r_opa >> w_amt) | (r_opa << (WIDTH - int'(w_amt)));

  // Bit WIDTH of w_sum is the carry for additions and the borrow for subtractions.
  always_comb begin
    w_sum   = '0;
    w_log   = '0;
    w_res   = '0;
    w_cout  = 1'b0;
    w_oflow = 1'b0;
    w_err   = 1'b0;
    w_g     = 1'b0;
    w_l     = 1'b0;
    w_e     = 1'b0;
    if (!w_dec_lat[2]) begin
      w_err = 1'b1;
    end else if (r_mode) begin
      case (r_cmd)
        4'd0: begin w_sum = w_ea + w_eb;                w_cout  = w_sum[WIDTH]; end
        4'd1: begin w_sum = w_ea - w_eb;                w_oflow = w_sum[WIDTH]; end
        4'd2: begin w_sum = w_ea + w_eb + w_cin_x;      w_cout  = w_sum[WIDTH]; end
        4'd3: begin w_sum = w_ea - w_eb - w_cin_x;      w_oflow = w_sum[WIDTH]; end
        4'd4: begin w_sum = w_ea + (WIDTH+1)'(1);       w_cout  = w_sum[WIDTH]; end
        4'd5: begin w_sum = w_ea - (WIDTH+1)'(1);       w_oflow = w_sum[WIDTH]; end
        4'd6: begin w_sum = w_eb + (WIDTH+1)'(1);       w_cout  = w_sum[WIDTH]; end
        4'd7: begin w_sum = w_eb - (WIDTH+1)'(1);       w_oflow = w_sum[WIDTH]; end
        4'd8: begin
          w_g = r_opa > r_opb;
          w_l = r_opa < r_opb;
          w_e = r_opa == r_opb;
        end
        default: ;
      endcase
      w_res = {{(WIDTH-1){1'b0}}, w_sum};
    end else begin
      case (r_cmd)
        4'd0:    w_log = r_opa & r_opb;
        4'd1:    w_log = ~(r_opa & r_opb);
        4'd2:    w_log = r_opa | r_opb;
        4'd3:    w_log = ~(r_opa | r_opb);
        4'd4:    w_log = r_opa ^ r_opb;
        4'd5:    w_log = ~(r_opa ^ r_opb);
        4'd6:    w_log = ~r_opa;
        4'd7:    w_log = ~r_opb;
        4'd8:    w_log = r_opa >> 1;
        4'd9:    w_log = r_opa << 1;
        4'd10:   w_log = r_opb >> 1;
        4'd11:   w_log = r_opb << 1;
        4'd12:   w_log = w_rol;
        4'd13:   w_log = w_ror;
        default: w_log = '0;
      endcase
      if (r_cmd == 4'd12 || r_cmd == 4'd13) w_err = |(r_opb >> SH);
      w_res = {{WIDTH{1'b0}}, w_log};
    end
  end

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH:0]     r_mul_a, r_mul_b;
  logic [2*WIDTH-1:0] w_prod;

  assign w_prod = (2*WIDTH)'(r_mul_a) * (2*WIDTH)'(r_mul_b);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else if (CE && r_state == S_EXEC && w_is_mul) begin
      if (r_cmd == 4'd9) begin
        r_mul_a <= w_ea + (WIDTH+1)'(1);
        r_mul_b <= w_eb + (WIDTH+1)'(1);
      end else begin
        r_mul_a <= {r_opa, 1'b0};
        r_mul_b <= w_eb;
      end
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_res       <= '0;
      r_res_valid <= 1'b0;
      {r_cout, r_oflow, r_err, r_g, r_l, r_e} <= '0;
    end else if (CE) begin
      r_res_valid <= 1'b0;
      if (r_state == S_EXEC && !w_is_mul) begin
        r_res       <= w_res;
        r_res_valid <= 1'b1;
        {r_cout, r_oflow, r_err, r_g, r_l, r_e} <= {w_cout, w_oflow, w_err, w_g, w_l, w_e};
      end else if (w_timeout) begin
        r_res       <= '0;
        r_res_valid <= 1'b1;
        {r_cout, r_oflow, r_err, r_g, r_l, r_e} <= 6'b001000;
      end
`ifdef ALU_PIPE_MUL_EN
      else if (r_state == S_MUL) begin
        r_res       <= w_prod;
        r_res_valid <= 1'b1;
        {r_cout, r_oflow, r_err, r_g, r_l, r_e} <= '0;
      end
`endif
    end
  end

  assign RES       = r_res;
  assign RES_VALID = r_res_valid;
  assign COUT      = r_cout;
  assign OFLOW     = r_oflow;
  assign ERR       = r_err;
  assign G         = r_g;
  assign L         = r_l;
  assign E         = r_e;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed checks of alu_pipe against an arithmetic reference model.
// Expectations follow ALU_PIPE_MUL_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_alu_pipe;
  localparam int W = 8;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST, CE, MODE, CIN;
  logic [3:0]     CMD;
  logic [1:0]     INP_VALID;
  logic [W-1:0]   OPA, OPB;
  logic [2*W-1:0] RES;
  logic           RES_VALID, COUT, OFLOW, ERR, G, L, E;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe #(.WIDTH(W), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
    .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .RES_VALID(RES_VALID),
    .COUT(COUT), .OFLOW(OFLOW), .ERR(ERR), .G(G), .L(L), .E(E)
  );

  always #5 CLK = ~CLK;

  // flags = {COUT, OFLOW, ERR, G, L, E}
  typedef struct {
    logic [2*W-1:0] res;
    logic [5:0]     flags;
    int             lat;
    logic [1:0]     need;
  } exp_t;

  function automatic exp_t model(bit mode, int cmd, longint a, longint b, bit cin);
    exp_t   m;
    longint s, r, lim, mask;
    bit     illegal, mul;
    int     n;
    lim = longint'(1) << W;
    mask = lim - 1;
    m.res = '0; m.flags = '0; m.lat = 1; m.need = 2'b11;
    s = 0; r = 0; illegal = 0; mul = 0;
    if (mode) begin
      case (cmd)
        0: begin s = a + b;       m.flags[5] = (s >= lim); end
        1: begin s = a - b;       m.flags[4] = (s < 0);    end
        2: begin s = a + b + cin; m.flags[5] = (s >= lim); end
        3: begin s = a - b - cin; m.flags[4] = (s < 0);    end
        4: begin s = a + 1; m.flags[5] = (s >= lim); m.need = 2'b01; end
        5: begin s = a - 1; m.flags[4] = (s < 0);    m.need = 2'b01; end
        6: begin s = b + 1; m.flags[5] = (s >= lim); m.need = 2'b10; end
        7: begin s = b - 1; m.flags[4] = (s < 0);    m.need = 2'b10; end
        8: m.flags[2:0] = {a > b, a < b, a == b};
        9: if (MUL_EN) begin s = (a + 1) * (b + 1); mul = 1; end else illegal = 1;
        10: if (MUL_EN) begin s = (2 * a) * b; mul = 1; end else illegal = 1;
        default: illegal = 1;
      endcase
      if (mul) begin
        m.res = 16'(s % (lim * lim));
        m.lat = 2;
      end else if (!illegal) begin
        m.res = 16'(s & ((lim * 2) - 1));
      end
    end else begin
      case (cmd)
        0: r = a & b;
        1: r = ~(a & b) & mask;
        2: r = a | b;
        3: r = ~(a | b) & mask;
        4: r = a ^ b;
        5: r = ~(a ^ b) & mask;
        6: begin r = ~a & mask; m.need = 2'b01; end
        7: begin r = ~b & mask; m.need = 2'b10; end
        8: begin r = a / 2; m.need = 2'b01; end
        9: begin r = (a * 2) & mask; m.need = 2'b01; end
        10: begin r = b / 2; m.need = 2'b10; end
        11: begin r = (b * 2) & mask; m.need = 2'b10; end
        12, 13: begin
          n = int'(b % W);
          m.flags[3] = (b >= W);
          for (int i = 0; i < W; i++) begin
            if (cmd == 12 && ((a >> ((i - n + W) % W)) & 1) != 0) r = r | (longint'(1) << i);
            if (cmd == 13 && ((a >> ((i + n) % W)) & 1) != 0)     r = r | (longint'(1) << i);
          end
        end
        default: illegal = 1;
      endcase
      if (!illegal) m.res = 16'(r);
    end
    if (illegal) begin
      m.res = '0;
      m.flags = 6'b001000;
    end
    return m;
  endfunction

  function automatic logic [5:0] flags_now();
    return {COUT, OFLOW, ERR, G, L, E};
  endfunction

  // One transaction from IDLE; optional garbage inputs while busy must be dropped.
  task automatic do_txn(input bit mode, input logic [3:0] cmd, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit cin, input logic [1:0] vld,
                        input bit garbage);
    exp_t m;
    m = model(mode, int'(cmd), longint'(a), longint'(b), cin);
    MODE = mode; CMD = cmd; OPA = a; OPB = b; CIN = cin; INP_VALID = vld;
    @(posedge CLK); #1;
    if (garbage) begin
      MODE = 1'($urandom); CMD = 4'($urandom); OPA = 8'($urandom); OPB = 8'($urandom);
      CIN = 1'($urandom); INP_VALID = 2'b11;
    end else begin
      INP_VALID = 2'b00;
    end
    for (int k = 1; k <= m.lat; k++) begin
      @(posedge CLK); #1;
      if (k < m.lat) begin
        n_checks++;
        if (RES_VALID !== 1'b0) begin
          n_fail++;
          $display("FAIL early_valid cmd=%0d got RES_VALID=%b want 0", cmd, RES_VALID);
        end
      end
    end
    INP_VALID = 2'b00;
    n_checks++;
    if ({RES_VALID, RES} !== {1'b1, m.res}) begin
      n_fail++;
      $display("FAIL txn_res mode=%0d cmd=%0d a=%02h b=%02h got valid=%b res=%04h want valid=1 res=%04h",
               mode, cmd, a, b, RES_VALID, RES, m.res);
    end
    n_checks++;
    if (flags_now() !== m.flags) begin
      n_fail++;
      $display("FAIL txn_flags mode=%0d cmd=%0d a=%02h b=%02h got %06b want %06b",
               mode, cmd, a, b, flags_now(), m.flags);
    end
    $display("txn mode=%0d cmd=%0d a=%02h b=%02h cin=%0d vld=%b -> res=%04h flags=%06b",
             mode, cmd, a, b, cin, vld, RES, flags_now());
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({RES_VALID, RES, flags_now()} !== '0) begin
      n_fail++;
      $display("FAIL %s got valid=%b res=%04h flags=%06b want all 0", name, RES_VALID, RES, flags_now());
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; CE = 1'b0; MODE = 0; CMD = 0; INP_VALID = 0; OPA = 0; OPB = 0; CIN = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset_ce0");
    RST = 1'b0; CE = 1'b1;
    @(posedge CLK); #1;
    check_zero("reset_idle");
  endtask

  task automatic test_add_carry();
    do_txn(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11, 1'b0);
    n_checks++;
    if ({RES, COUT} !== {16'h0100, 1'b1}) begin
      n_fail++;
      $display("FAIL add_carry got res=%04h cout=%b want 0100 1", RES, COUT);
    end
  endtask

  task automatic test_mul();
    do_txn(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11, 1'b0);
    n_checks++;
    if ({RES, ERR} !== (MUL_EN ? {16'd20, 1'b0} : {16'd0, 1'b1})) begin
      n_fail++;
      $display("FAIL mul_inc got res=%0d err=%b want res=%0d err=%b", RES, ERR,
               MUL_EN ? 20 : 0, !MUL_EN);
    end
    do_txn(1'b1, 4'd10, 8'hFF, 8'hFF, 1'b0, 2'b11, 1'b1);
  endtask

  task automatic test_wait();
    MODE = 1'b1; CMD = 4'd1; OPA = 8'd20; OPB = 8'd99; CIN = 1'b0; INP_VALID = 2'b01;
    @(posedge CLK); #1;
    INP_VALID = 2'b00; MODE = 1'b0; CMD = 4'd4;
    repeat (2) begin
      @(posedge CLK); #1;
      n_checks++;
      if (RES_VALID !== 1'b0) begin n_fail++; $display("FAIL wait_quiet got %b want 0", RES_VALID); end
    end
    OPB = 8'd7; INP_VALID = 2'b10;
    @(posedge CLK); #1;
    INP_VALID = 2'b00;
    n_checks++;
    if (RES_VALID !== 1'b0) begin n_fail++; $display("FAIL wait_accept_edge got %b want 0", RES_VALID); end
    @(posedge CLK); #1;
    n_checks++;
    if ({RES_VALID, RES, flags_now()} !== {1'b1, 16'd13, 6'b0}) begin
      n_fail++;
      $display("FAIL wait_sub got valid=%b res=%04h flags=%06b want 1 000d 000000", RES_VALID, RES, flags_now());
    end
    $display("txn wait SUB 20-7 -> res=%04h", RES);
  endtask

  task automatic test_timeout();
    MODE = 1'b1; CMD = 4'd0; OPA = 8'h33; INP_VALID = 2'b01;
    @(posedge CLK); #1;
    INP_VALID = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (k < 16 && RES_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_early cycle=%0d got valid=%b want 0", k, RES_VALID);
      end else if (k == 16 && {RES_VALID, RES, flags_now()} !== {1'b1, 16'd0, 6'b001000}) begin
        n_fail++;
        $display("FAIL timeout_err got valid=%b res=%04h flags=%06b want 1 0000 001000", RES_VALID, RES, flags_now());
      end
    end
    @(posedge CLK); #1;
    n_checks++;
    if (RES_VALID !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse got %b want 0", RES_VALID); end
    $display("txn timeout ADD missing OPB -> err=%b", ERR);
  endtask

  task automatic test_cmp_rol();
    do_txn(1'b1, 4'd8, 8'd5, 8'd9, 1'b0, 2'b11, 1'b0);
    n_checks++;
    if ({G, L, E} !== 3'b010) begin n_fail++; $display("FAIL cmp_gle got %b want 010", {G, L, E}); end
    do_txn(1'b0, 4'd12, 8'h81, 8'h09, 1'b0, 2'b11, 1'b0);
    n_checks++;
    if ({ERR, RES} !== {1'b1, 16'h0003}) begin
      n_fail++;
      $display("FAIL rol_err got err=%b res=%04h want 1 0003", ERR, RES);
    end
    do_txn(1'b0, 4'd13, 8'h81, 8'h03, 1'b0, 2'b11, 1'b0);
    do_txn(1'b0, 4'd15, 8'h12, 8'h34, 1'b0, 2'b11, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_txn(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11, 1'b0);
    MODE = 1'b1; CMD = 4'd1; OPA = 8'd9; INP_VALID = 2'b01;
    @(posedge CLK); #1;
    INP_VALID = 2'b00;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_zero("reset_in_wait");
    repeat (3) begin
      @(posedge CLK); #1;
      check_zero("after_wait_reset");
    end
    do_txn(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11, 1'b0);
    MODE = 1'b1; CMD = MUL_EN ? 4'd9 : 4'd0; OPA = 8'd7; OPB = 8'd8; INP_VALID = 2'b11;
    @(posedge CLK); #1;
    INP_VALID = 2'b00;
    if (MUL_EN) begin
      @(posedge CLK); #1;
      n_checks++;
      if (RES_VALID !== 1'b0) begin n_fail++; $display("FAIL mul_stage1 got %b want 0", RES_VALID); end
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_zero("reset_in_flight");
    repeat (3) begin
      @(posedge CLK); #1;
      check_zero("after_flight_reset");
    end
    $display("txn reset mid-operation -> valid=%b res=%04h", RES_VALID, RES);
  endtask

  task automatic test_ce_stall();
    exp_t m;
    logic [3:0] cmd;
    cmd = MUL_EN ? 4'd10 : 4'd0;
    m = model(1'b1, int'(cmd), 64'h80, 64'hFF, 1'b0);
    MODE = 1'b1; CMD = cmd; OPA = 8'h80; OPB = 8'hFF; CIN = 1'b0; INP_VALID = 2'b11;
    @(posedge CLK); #1;
    INP_VALID = 2'b00; CE = 1'b0;
    repeat (5) begin
      @(posedge CLK); #1;
      n_checks++;
      if (RES_VALID !== 1'b0) begin n_fail++; $display("FAIL ce_hold got valid=%b want 0", RES_VALID); end
    end
    CE = 1'b1;
    for (int k = 1; k <= m.lat; k++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (k < m.lat && RES_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL ce_early got valid=%b want 0", RES_VALID);
      end else if (k == m.lat && {RES_VALID, RES, flags_now()} !== {1'b1, m.res, m.flags}) begin
        n_fail++;
        $display("FAIL ce_result got valid=%b res=%04h flags=%06b want 1 %04h %06b",
                 RES_VALID, RES, flags_now(), m.res, m.flags);
      end
    end
    $display("txn ce stall cmd=%0d -> res=%04h", cmd, RES);
  endtask

  task automatic test_random();
    exp_t        m;
    bit          mode, cin;
    logic [3:0]  cmd;
    logic [W-1:0] a, b;
    logic [1:0]  vld;
    for (int i = 0; i < 150; i++) begin
      mode = 1'($urandom); cmd = 4'($urandom); cin = 1'($urandom);
      a = 8'($urandom); b = 8'($urandom);
      if ($urandom_range(0, 4) == 0) a = 8'hFF;
      if ($urandom_range(0, 4) == 0) b = 8'h00;
      m = model(mode, int'(cmd), longint'(a), longint'(b), cin);
      vld = 2'b11;
      if (m.need != 2'b11 && $urandom_range(0, 1) == 1) vld = m.need;
      do_txn(mode, cmd, a, b, cin, vld, 1'(i % 2));
      @(posedge CLK); #1;
      n_checks++;
      if ({RES_VALID, RES} !== {1'b0, m.res}) begin
        n_fail++;
        $display("FAIL hold got valid=%b res=%04h want 0 %04h", RES_VALID, RES, m.res);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_carry();
    test_mul();
    test_wait();
    test_timeout();
    test_cmp_rol();
    test_reset_mid();
    test_ce_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
